// File: rtl/pwm_pkg.sv
// Shared PWM types: capture FSM state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } cap_state_t;

    localparam int PWM_W_DEF       = 16;
    localparam int PWM_PS_W_DEF    = 8;
    localparam int PWM_SYNC_FF_DEF = 2;

endpackage

// File: rtl/pwm_capture_if.sv
// Register-bank side of the capture block: control in, results and status out.
// Latency: n/a (wires only).
// Backpressure: none; capture_vld is a fire-and-forget strobe.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int W    = PWM_W_DEF,
    parameter int PS_W = PWM_PS_W_DEF
);
    logic            en;
    logic            clear;
    logic            polarity;
    logic [PS_W-1:0] prescale;
    logic [W-1:0]    high_time;
    logic [W-1:0]    period_val;
    logic            capture_vld;
    logic            overflow;
    logic [1:0]      state_o;

    // Register block drives control and reads results.
    modport master (
        output en, clear, polarity, prescale,
        input  high_time, period_val, capture_vld, overflow, state_o
    );

    // Capture block consumes control and drives results.
    modport slave (
        input  en, clear, polarity, prescale,
        output high_time, period_val, capture_vld, overflow, state_o
    );
endinterface

// File: rtl/sync_edge_det.sv
// Pin synchronizer with polarity normalisation and active/inactive edge strobes.
// Latency: pin change -> strobe usable at the (SYNC_FF+1)th clk edge.
// Backpressure: none; strobes are single-cycle and never held.
module sync_edge_det #(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic polarity,
    output logic rise,
    output logic fall
);
    logic [SYNC_FF-1:0] sync_q;
    logic               lvl;
    logic               lvl_q;

    // After polarity normalisation, 1 always means "active".
    assign lvl  = sync_q[SYNC_FF-1] ^ ~polarity;
    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

    // Metastability chain plus one stage of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_FF-2:0], pin};
            lvl_q  <= lvl;
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: active time and period of pwm_in in prescaled ticks.
// Latency: results + capture_vld appear SYNC_FF+1 clk after the closing pin edge.
// Backpressure: none; results are overwritten by the next capture.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int W       = PWM_W_DEF,
    parameter int PS_W    = PWM_PS_W_DEF,
    parameter int SYNC_FF = PWM_SYNC_FF_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    pwm_capture_if.slave  bus
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic            act_edge;
    logic            inact_edge;
    logic            tick;
    logic            pre_clr;
    logic [PS_W-1:0] pre_q;
    cap_state_t      state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]    hi_snap_q, hi_snap_d;
    logic [W-1:0]    high_q, high_d;
    logic [W-1:0]    per_q, per_d;
    logic            ovf_q, ovf_d;
    logic            vld_q, vld_d;
    logic            cnt_wrap;

    sync_edge_det #(.SYNC_FF(SYNC_FF)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin      (pwm_in),
        .polarity (bus.polarity),
        .rise     (act_edge),
        .fall     (inact_edge)
    );

    // >= rather than == so a prescale lowered below the current count wraps at once.
    assign tick     = (pre_q >= bus.prescale);
    assign cnt_inc  = tick ? cnt_q + W'(1) : cnt_q;
    assign cnt_wrap = tick && (cnt_q == CNT_MAX);
    // An accepted active edge realigns the tick phase to the start of the period.
    assign pre_clr  = bus.clear ||
                      (bus.en && act_edge && (state_q == ARM || state_q == LOW));

    // Prescaler: free-running 0..prescale, restarted on accepted active edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                pre_q <= '0;
        else if (pre_clr || tick)  pre_q <= '0;
        else                       pre_q <= pre_q + PS_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: clear, then enable, then edges, then counter overflow.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = bus.en ? ARM : IDLE;
        end else if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (act_edge) state_d = HIGH;
                HIGH:    if (inact_edge) state_d = LOW;
                         else if (cnt_wrap) state_d = ARM;
                LOW:     if (act_edge) state_d = HIGH;
                         else if (cnt_wrap) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: counter, high-time snapshot, results and sticky overflow.
    always_comb begin
        cnt_d     = cnt_q;
        hi_snap_d = hi_snap_q;
        high_d    = high_q;
        per_d     = per_q;
        ovf_d     = ovf_q;
        vld_d     = 1'b0;
        if (bus.clear) begin
            cnt_d  = '0;
            high_d = '0;
            per_d  = '0;
            ovf_d  = 1'b0;
        end else if (!bus.en) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                ARM: begin
                    cnt_d = '0;
                end
                HIGH: begin
                    if (inact_edge) begin
                        hi_snap_d = cnt_inc;
                        cnt_d     = cnt_inc;
                    end else if (cnt_wrap) begin
                        ovf_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (act_edge) begin
                        per_d  = cnt_inc;
                        high_d = hi_snap_q;
                        vld_d  = 1'b1;
                        cnt_d  = '0;
                    end else if (cnt_wrap) begin
                        ovf_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    // Datapath registers; results only move together with capture_vld or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_snap_q <= '0;
            high_q    <= '0;
            per_q     <= '0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_snap_q <= hi_snap_d;
            high_q    <= high_d;
            per_q     <= per_d;
            ovf_q     <= ovf_d;
            vld_q     <= vld_d;
        end
    end

    assign bus.high_time   = high_q;
    assign bus.period_val  = per_q;
    assign bus.capture_vld = vld_q;
    assign bus.overflow    = ovf_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboarded bench for pwm_capture: random and directed PWM waveforms.
// Latency: checks captures whenever capture_vld fires, independent of stimulus.
// Backpressure: n/a.
module tb_pwm_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_in = 1'b0;

    pwm_capture_if #(.W(16), .PS_W(8)) bus ();

    pwm_capture #(.W(16), .PS_W(8), .SYNC_FF(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ht;
        int per;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Waveform model state.
    bit   pol     = 1'b1;
    int   cur_p   = 0;
    bit   started = 1'b0;
    int   prev_hi = 0;
    int   prev_lo = 0;
    int   last_ht = 0;
    int   last_per = 0;

    task automatic chk(string nm, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: ticks in an interval of n clk after an active edge = n / (prescale+1).
    task automatic push_exp(int h, int t);
        exp_t e;
        int d;
        d = cur_p + 1;
        if (t / d >= 65536) return;
        e.ht  = h / d;
        e.per = t / d;
        exp_q.push_back(e);
        last_ht  = e.ht;
        last_per = e.per;
    endtask

    task automatic period(int hi, int lo);
        pwm_in = pol;
        if (started) push_exp(prev_hi, prev_hi + prev_lo);
        cyc(hi);
        pwm_in = !pol;
        cyc(lo);
        started = 1'b1;
        prev_hi = hi;
        prev_lo = lo;
    endtask

    task automatic close_edge();
        pwm_in = pol;
        if (started) push_exp(prev_hi, prev_hi + prev_lo);
        started = 1'b0;
        cyc(10);
    endtask

    task automatic setup(int p, bit pl);
        bus.en = 1'b0;
        pol = pl;
        cur_p = p;
        bus.polarity = pl;
        bus.prescale = 8'(p);
        pwm_in = !pl;
        started = 1'b0;
        cyc(6);
        bus.en = 1'b1;
        cyc(3);
        chk("state_armed", bus.state_o, pwm_pkg::ARM);
    endtask

    // Monitor: pops expectations on every capture and checks results hold otherwise.
    int         vld_run = 0;
    logic       clr_d = 1'b0;
    logic [15:0] prev_ht = '0;
    logic [15:0] prev_per = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.capture_vld) begin
                vld_run++;
                chk("vld_width", vld_run, 1);
                chk("capture_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("high_time", bus.high_time, mon_e.ht);
                    chk("period_val", bus.period_val, mon_e.per);
                end
            end else begin
                vld_run = 0;
                if (!clr_d) begin
                    chk("high_hold", bus.high_time, prev_ht);
                    chk("period_hold", bus.period_val, prev_per);
                end
            end
        end else begin
            vld_run = 0;
        end
        clr_d    = bus.clear;
        prev_ht  = bus.high_time;
        prev_per = bus.period_val;
    end

    initial begin
        bus.en = 1'b0;
        bus.clear = 1'b0;
        bus.polarity = 1'b1;
        bus.prescale = '0;
        cyc(3);
        chk("rst_high_time", bus.high_time, 0);
        chk("rst_period", bus.period_val, 0);
        chk("rst_vld", bus.capture_vld, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_state", bus.state_o, pwm_pkg::IDLE);
        rst_n = 1'b1;
        cyc(2);

        // 10 high / 30 low, no prescale.
        setup(0, 1'b1);
        repeat (3) period(10, 30);
        close_edge();

        // Prescale by 4: 40/40 clk -> 10/20 ticks.
        setup(3, 1'b1);
        repeat (3) period(40, 40);
        close_edge();

        // Active-low pulse.
        setup(0, 1'b0);
        repeat (3) period(25, 75);
        close_edge();

        // Random waveforms, prescale and polarity.
        for (int s = 0; s < 4; s++) begin
            setup(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 6; k++)
                period(int'($urandom_range(3, 50)), int'($urandom_range(3, 50)));
            close_edge();
        end

        // Overflow: active held beyond 2^16 ticks.
        setup(0, 1'b1);
        pwm_in = 1'b1;
        cyc(70000);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_state", bus.state_o, pwm_pkg::ARM);
        chk("ovf_high_keep", bus.high_time, last_ht);
        chk("ovf_period_keep", bus.period_val, last_per);
        pwm_in = 1'b0;
        cyc(5);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("clr_overflow", bus.overflow, 0);
        chk("clr_high_time", bus.high_time, 0);
        chk("clr_period", bus.period_val, 0);
        chk("clr_state", bus.state_o, pwm_pkg::ARM);

        // Abort mid-HIGH via en, then re-arm.
        setup(0, 1'b1);
        pwm_in = 1'b1;
        cyc(8);
        chk("abort_in_high", bus.state_o, pwm_pkg::HIGH);
        bus.en = 1'b0;
        cyc(2);
        chk("abort_idle", bus.state_o, pwm_pkg::IDLE);
        pwm_in = 1'b0;
        cyc(5);
        bus.en = 1'b1;
        cyc(3);
        started = 1'b0;
        repeat (3) period(10, 30);
        close_edge();

        // Asynchronous reset while in LOW.
        setup(0, 1'b1);
        pwm_in = 1'b1;
        cyc(10);
        pwm_in = 1'b0;
        cyc(10);
        chk("pre_rst_low", bus.state_o, pwm_pkg::LOW);
        rst_n = 1'b0;
        #2;
        chk("arst_high_time", bus.high_time, 0);
        chk("arst_period", bus.period_val, 0);
        chk("arst_overflow", bus.overflow, 0);
        chk("arst_vld", bus.capture_vld, 0);
        chk("arst_state", bus.state_o, pwm_pkg::IDLE);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        started = 1'b0;
        repeat (3) period(10, 30);
        close_edge();

        cyc(20);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
